// File: rtl/cyclotron_fetch_pkg.sv
// Shared types and constants for the Cyclotron instruction-fetch requester.
//   fetch_slot_t : one reorder-ring entry (pending/done/kill flags, fetch pc, instruction)
//   slot_idx_t   : ring pointer / imem tag index type
//   ptr_inc      : wrapping pointer increment (DEPTH is a power of two)
package cyclotron_fetch_pkg;

    localparam int ARCH_LEN      = 32;
    localparam int INST_BITS     = 64;
    localparam int IMEM_TAG_BITS = 64;
    localparam int DEPTH         = 4;
    localparam int PC_STEP       = 8;
    localparam logic [ARCH_LEN-1:0] START_PC = 32'h8000_0000;

    localparam int SLOT_IDX_BITS = $clog2(DEPTH);
    // One extra bit so that "full" (count == DEPTH) is representable.
    localparam int COUNT_BITS    = SLOT_IDX_BITS + 1;

    typedef logic [SLOT_IDX_BITS-1:0] slot_idx_t;

    typedef struct packed {
        logic                 pending;
        logic                 done;
        logic                 kill;
        logic [ARCH_LEN-1:0]  pc;
        logic [INST_BITS-1:0] inst;
    } fetch_slot_t;

    // DEPTH is a power of two, so natural overflow of the index gives the wrap.
    function automatic slot_idx_t ptr_inc(input slot_idx_t ptr);
        return ptr + slot_idx_t'(1);
    endfunction

endpackage

// File: rtl/fetch_rob.sv
// Reorder ring for in-flight instruction fetches.
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   alloc, alloc_pc       : allocate the tail slot for a new fetch at alloc_pc
//   fill, fill_idx/inst   : write a returned instruction into slot fill_idx and mark it done
//   fill_ok               : slot fill_idx is pending and not yet done (response acceptable)
//   kill_all              : mark every pending slot as killed (redirect)
//   pop                   : free the head slot and advance head
//   head_slot             : contents of the head slot
//   tail, count           : allocation pointer and number of allocated slots
module fetch_rob
    import cyclotron_fetch_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  alloc,
    input  logic [ARCH_LEN-1:0]   alloc_pc,
    input  logic                  fill,
    input  slot_idx_t             fill_idx,
    input  logic [INST_BITS-1:0]  fill_inst,
    input  logic                  kill_all,
    input  logic                  pop,
    output logic                  fill_ok,
    output fetch_slot_t           head_slot,
    output slot_idx_t             tail,
    output logic [COUNT_BITS-1:0] count
);

    slot_idx_t             head_reg, head_next;
    slot_idx_t             tail_reg, tail_next;
    logic [COUNT_BITS-1:0] count_reg, count_next;

    fetch_slot_t slot_view [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_slot
            fetch_slot_t slot_reg, slot_next;

            // Update order matters: a slot killed in the same cycle its
            // response lands keeps the data but is dropped later, and a
            // pop always leaves the slot fully free.
            always_comb begin
                slot_next = slot_reg;
                if (alloc && tail_reg == slot_idx_t'(gi)) begin
                    slot_next.pending = 1'b1;
                    slot_next.done    = 1'b0;
                    slot_next.kill    = 1'b0;
                    slot_next.pc      = alloc_pc;
                end
                if (fill && fill_idx == slot_idx_t'(gi)) begin
                    slot_next.inst = fill_inst;
                    slot_next.done = 1'b1;
                end
                if (kill_all && slot_reg.pending) begin
                    slot_next.kill = 1'b1;
                end
                if (pop && head_reg == slot_idx_t'(gi)) begin
                    slot_next.pending = 1'b0;
                    slot_next.done    = 1'b0;
                    slot_next.kill    = 1'b0;
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    slot_reg <= '0;
                end else begin
                    slot_reg <= slot_next;
                end
            end

            assign slot_view[gi] = slot_reg;
        end
    endgenerate

    always_comb begin
        head_next  = pop   ? ptr_inc(head_reg) : head_reg;
        tail_next  = alloc ? ptr_inc(tail_reg) : tail_reg;
        count_next = count_reg;
        case ({alloc, pop})
            2'b10:   count_next = count_reg + COUNT_BITS'(1);
            2'b01:   count_next = count_reg - COUNT_BITS'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    assign head_slot = slot_view[head_reg];
    assign fill_ok   = slot_view[fill_idx].pending & ~slot_view[fill_idx].done;
    assign tail      = tail_reg;
    assign count     = count_reg;

endmodule

// File: rtl/cyclotron_fetch_requester.sv
// Requester side of the Cyclotron instruction-memory fetch interface.
// Issues sequential, tagged fetches (no backpressure), reorders out-of-order
// responses by tag and delivers instructions in program order.
// Ports:
//   clock, reset                 : clock, synchronous active-high reset
//   fetch_en                     : allow new fetch issue
//   redirect_valid, redirect_pc  : flush in-flight work, restart at redirect_pc
//   imem_req_*                   : fetch request (valid, tag = slot index, pc)
//   imem_resp_*                  : fetch response (valid, tag, instruction)
//   inst_valid/ready, inst_bits_*: in-order instruction delivery
//   resp_err                     : sticky flag for a response that matched no waiting slot
module cyclotron_fetch_requester
    import cyclotron_fetch_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     fetch_en,
    input  logic                     redirect_valid,
    input  logic [ARCH_LEN-1:0]      redirect_pc,
    output logic                     imem_req_valid,
    output logic [IMEM_TAG_BITS-1:0] imem_req_bits_tag,
    output logic [ARCH_LEN-1:0]      imem_req_bits_pc,
    input  logic                     imem_resp_valid,
    input  logic [IMEM_TAG_BITS-1:0] imem_resp_bits_tag,
    input  logic [INST_BITS-1:0]     imem_resp_bits_inst,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [ARCH_LEN-1:0]      inst_bits_pc,
    output logic [INST_BITS-1:0]     inst_bits_inst,
    output logic                     resp_err
);

    logic [ARCH_LEN-1:0]   pc_reg, pc_next;
    logic                  resp_err_reg, resp_err_next;

    logic                  issue;
    logic                  resp_in_range;
    slot_idx_t             resp_idx;
    logic                  fill;
    logic                  fill_ok;
    logic                  resp_drop;
    logic                  deliver;
    logic                  head_ready;
    logic                  pop;
    logic                  kill_all;
    fetch_slot_t           head_slot;
    slot_idx_t             tail;
    logic [COUNT_BITS-1:0] count;

    fetch_rob u_rob (
        .clock     (clock),
        .reset     (reset),
        .alloc     (issue),
        .alloc_pc  (pc_reg),
        .fill      (fill),
        .fill_idx  (resp_idx),
        .fill_inst (imem_resp_bits_inst),
        .kill_all  (kill_all),
        .pop       (pop),
        .fill_ok   (fill_ok),
        .head_slot (head_slot),
        .tail      (tail),
        .count     (count)
    );

    assign issue = ~reset & fetch_en & ~redirect_valid & (count != COUNT_BITS'(DEPTH));

    // A tag is usable only if every bit above the slot index is zero.
    assign resp_in_range = (imem_resp_bits_tag >> SLOT_IDX_BITS) == '0;
    assign resp_idx      = imem_resp_bits_tag[SLOT_IDX_BITS-1:0];
    assign fill          = ~reset & imem_resp_valid & resp_in_range & fill_ok;
    assign resp_drop     = ~reset & imem_resp_valid & ~(resp_in_range & fill_ok);

    assign kill_all = ~reset & redirect_valid;

    // Delivery reads only registered slot state, so a response is never
    // visible on inst_valid in the cycle it arrives.
    assign head_ready = head_slot.pending & head_slot.done;
    assign deliver    = ~reset & head_ready & ~head_slot.kill & ~redirect_valid;
    assign pop        = ~reset & head_ready & (head_slot.kill | (deliver & inst_ready));

    always_comb begin
        pc_next = pc_reg;
        if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if (issue) begin
            pc_next = pc_reg + ARCH_LEN'(PC_STEP);
        end
        resp_err_next = resp_err_reg | resp_drop;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_reg       <= START_PC;
            resp_err_reg <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            resp_err_reg <= resp_err_next;
        end
    end

    assign imem_req_valid    = issue;
    assign imem_req_bits_tag = reset ? '0 : {{(IMEM_TAG_BITS-SLOT_IDX_BITS){1'b0}}, tail};
    assign imem_req_bits_pc  = reset ? '0 : pc_reg;
    assign inst_valid        = deliver;
    assign inst_bits_pc      = deliver ? head_slot.pc   : '0;
    assign inst_bits_inst    = deliver ? head_slot.inst : '0;
    assign resp_err          = resp_err_reg & ~reset;

endmodule
